// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding selects, load-use stall and branch flush.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_ctrl #(
    parameter int unsigned NSTAGE    = 2,
    parameter int unsigned FLUSH_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_rf_en,
    input  logic       id_is_load,
    input  logic       brj,
    output logic [2:0] sel_a_fwd,
    output logic [2:0] sel_b_fwd,
    output logic       stall,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic       flush
);

    // Index 0 holds the youngest in-flight instruction.
    logic [NSTAGE-1:0]      valid_q, valid_d;
    logic [NSTAGE-1:0][4:0] rd_q, rd_d;
    logic [NSTAGE-1:0]      rf_en_q, rf_en_d;
    logic [NSTAGE-1:0]      is_load_q, is_load_d;
    logic [1:0]             fcnt_q, fcnt_d;

    always_comb begin
        flush = brj | (fcnt_q != 2'd0);
        stall = id_valid & ~flush & valid_q[0] & rf_en_q[0] & is_load_q[0] &
                (rd_q[0] != 5'd0) & ((rd_q[0] == id_rs1) | (rd_q[0] == id_rs2));
    end

    // Walk oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        sel_a_fwd = '0;
        sel_b_fwd = '0;
        for (int unsigned k = NSTAGE; k > 0; k--) begin
            if (valid_q[k-1] && rf_en_q[k-1] && (rd_q[k-1] != 5'd0)) begin
                if (rd_q[k-1] == id_rs1) sel_a_fwd = 3'(k);
                if (rd_q[k-1] == id_rs2) sel_b_fwd = 3'(k);
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        rd_d         = rd_q;
        rf_en_d      = rf_en_q;
        is_load_d    = is_load_q;
        valid_d[0]   = id_valid & ~stall & ~flush;
        rd_d[0]      = id_rd;
        rf_en_d[0]   = id_rf_en;
        is_load_d[0] = id_is_load;
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            valid_d[k]   = valid_q[k-1];
            rd_d[k]      = rd_q[k-1];
            rf_en_d[k]   = rf_en_q[k-1];
            is_load_d[k] = is_load_q[k-1];
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (brj)                  fcnt_d = 2'(FLUSH_CYC - 1);
        else if (fcnt_q != 2'd0)  fcnt_d = fcnt_q - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            rd_q      <= '0;
            rf_en_q   <= '0;
            is_load_q <= '0;
            fcnt_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            rf_en_q   <= rf_en_d;
            is_load_q <= is_load_d;
            fcnt_q    <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, flush};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two configurations driven with identical
// decode stimulus, directed scenarios plus randomized traffic against a history model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rf_en, id_is_load, brj;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [2:0]  sel_a [2];
    logic [2:0]  sel_b [2];
    logic        stall_o [2];
    logic        flush_o [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] scnt_o [2];
    logic [31:0] fcnt_o [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.NSTAGE(2), .FLUSH_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rf_en(id_rf_en), .id_is_load(id_is_load), .brj(brj),
        .sel_a_fwd(sel_a[0]), .sel_b_fwd(sel_b[0]), .stall(stall_o[0]),
`ifdef HAZARD_PERF_EN
        .stall_cnt(scnt_o[0]), .flush_cnt(fcnt_o[0]),
`endif
        .flush(flush_o[0])
    );

    hazard_ctrl #(.NSTAGE(3), .FLUSH_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rf_en(id_rf_en), .id_is_load(id_is_load), .brj(brj),
        .sel_a_fwd(sel_a[1]), .sel_b_fwd(sel_b[1]), .stall(stall_o[1]),
`ifdef HAZARD_PERF_EN
        .stall_cnt(scnt_o[1]), .flush_cnt(fcnt_o[1]),
`endif
        .flush(flush_o[1])
    );

    // Reference model: history of issued instructions (index 0 = most recent)
    // and the number of cycles since the last taken branch.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       en;
        logic       ld;
    } ent_t;

    int   nst [2] = '{2, 3};
    int   fcy [2] = '{2, 3};
    ent_t hist [2][4];
    int   since [2];
    int   sc_m [2];
    int   fc_m [2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) hist[i][k] = '0;
            since[i] = 100;
            sc_m[i]  = 0;
            fc_m[i]  = 0;
        end
    endtask

    function automatic int m_sel(int i, logic [4:0] src);
        if (src == 5'd0) return 0;
        for (int k = 0; k < nst[i]; k++)
            if (hist[i][k].v && hist[i][k].en && hist[i][k].rd == src) return k + 1;
        return 0;
    endfunction

    function automatic bit m_flush(int i);
        return brj || (since[i] < fcy[i]);
    endfunction

    function automatic bit m_stall(int i);
        return id_valid && !m_flush(i) && hist[i][0].v && hist[i][0].en && hist[i][0].ld &&
               hist[i][0].rd != 5'd0 && (hist[i][0].rd == id_rs1 || hist[i][0].rd == id_rs2);
    endfunction

    task automatic tick();
        bit s [2];
        bit f [2];
        for (int i = 0; i < 2; i++) begin
            s[i] = m_stall(i);
            f[i] = m_flush(i);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (s[i]) sc_m[i]++;
                if (f[i]) fc_m[i]++;
                for (int k = nst[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = {id_valid && !s[i] && !f[i], id_rd, id_rf_en, id_is_load};
                since[i] = brj ? 1 : (since[i] < 100 ? since[i] + 1 : since[i]);
            end
        end
        #1;
    endtask

    task automatic set_id(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          logic en, logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rf_en = en; id_is_load = ld;
    endtask

    task automatic idle(int n);
        brj = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_reset();
        brj = 1'b0;
        set_id(1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_a[i] !== 3'd0 || sel_b[i] !== 3'd0 || stall_o[i] !== 1'b0 || flush_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got sel_a=%0d sel_b=%0d stall=%b flush=%b want 0 0 0 0",
                         i, sel_a[i], sel_b[i], stall_o[i], flush_o[i]);
            end
        end
        brj = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (flush_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_flush_eq_brj dut%0d got flush=%b want 1", i, flush_o[i]);
            end
        end
        tick();
        rst = 1'b0;
        brj = 1'b0;
        set_id(1'b1, 5'd5, 5'd7, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_a[i] !== 3'd0 || sel_b[i] !== 3'd0 || stall_o[i] !== 1'b0 || flush_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL after_reset dut%0d got sel_a=%0d sel_b=%0d stall=%b flush=%b want 0 0 0 0",
                         i, sel_a[i], sel_b[i], stall_o[i], flush_o[i]);
            end
        end
        tick();
    endtask

    task automatic test_alu_fwd();
        idle(3);
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_a[i] !== 3'd1 || sel_b[i] !== 3'd0 || stall_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL alu_fwd dut%0d got sel_a=%0d sel_b=%0d stall=%b want 1 0 0",
                         i, sel_a[i], sel_b[i], stall_o[i]);
            end
        end
        tick();
    endtask

    task automatic test_two_back();
        idle(3);
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_b[i] !== 3'd1 || sel_a[i] !== 3'd0) begin
                errors++;
                $display("FAIL youngest_prio dut%0d got sel_a=%0d sel_b=%0d want 0 1", i, sel_a[i], sel_b[i]);
            end
        end
        idle(3);
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd7, 5'd10, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_b[i] !== 3'd2 || sel_a[i] !== 3'd1) begin
                errors++;
                $display("FAIL two_back dut%0d got sel_a=%0d sel_b=%0d want 1 2", i, sel_a[i], sel_b[i]);
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        idle(3);
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL load_use_stall dut%0d got stall=%b want 1", i, stall_o[i]);
            end
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall_o[i] !== 1'b0 || sel_a[i] !== 3'd2) begin
                errors++;
                $display("FAIL load_use_resolve dut%0d got stall=%b sel_a=%0d want 0 2",
                         i, stall_o[i], sel_a[i]);
            end
        end
        tick();
    endtask

    task automatic test_x0();
        idle(3);
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_a[i] !== 3'd0 || sel_b[i] !== 3'd0 || stall_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL x0_no_fwd dut%0d got sel_a=%0d sel_b=%0d stall=%b want 0 0 0",
                         i, sel_a[i], sel_b[i], stall_o[i]);
            end
        end
        tick();
    endtask

    task automatic test_flush();
        bit want_b [3] = '{1'b1, 1'b1, 1'b0};
        bit want_a [3] = '{1'b1, 1'b0, 1'b0};
        idle(4);
        brj = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (flush_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL flush_brj dut%0d got flush=%b want 1", i, flush_o[i]);
            end
        end
        tick();
        brj = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (flush_o[0] !== want_a[c] || flush_o[1] !== want_b[c]) begin
                errors++;
                $display("FAIL flush_tail c%0d got a=%b b=%b want a=%b b=%b",
                         c, flush_o[0], flush_o[1], want_a[c], want_b[c]);
            end
            tick();
        end
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        brj = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall_o[i] !== 1'b0 || flush_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL flush_beats_stall dut%0d got stall=%b flush=%b want 0 1",
                         i, stall_o[i], flush_o[i]);
            end
        end
        tick();
        brj = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_a[i] !== 3'd2 || stall_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL flush_keeps_older dut%0d got sel_a=%0d stall=%b want 2 0",
                         i, sel_a[i], stall_o[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid_flush();
        idle(4);
        brj = 1'b1;
        tick();
        brj = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL midflush_pre dut1 got flush=%b want 1", flush_o[1]);
        end
        rst = 1'b1;
        m_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (flush_o[i] !== 1'b0 || stall_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_rst_abandon dut%0d got flush=%b stall=%b want 0 0",
                         i, flush_o[i], stall_o[i]);
            end
        end
        tick();
        rst = 1'b0;
        set_id(1'b1, 5'd3, 5'd7, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (flush_o[i] !== 1'b0 || stall_o[i] !== 1'b0 || sel_a[i] !== 3'd0 || sel_b[i] !== 3'd0) begin
                errors++;
                $display("FAIL post_rst_clean dut%0d got flush=%b stall=%b sel_a=%0d sel_b=%0d want 0",
                         i, flush_o[i], stall_o[i], sel_a[i], sel_b[i]);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (scnt_o[i] !== 32'd0 || fcnt_o[i] !== 32'd0) begin
                errors++;
                $display("FAIL post_rst_cnt dut%0d got stall_cnt=%0d flush_cnt=%0d want 0 0",
                         i, scnt_o[i], fcnt_o[i]);
            end
`endif
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (rst) m_reset();
            brj = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2) == 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (sel_a[i] !== 3'(m_sel(i, id_rs1)) || sel_b[i] !== 3'(m_sel(i, id_rs2)) ||
                    stall_o[i] !== m_stall(i) || flush_o[i] !== m_flush(i)) begin
                    errors++;
                    $display("FAIL random n%0d dut%0d got a=%0d b=%0d s=%b f=%b want a=%0d b=%0d s=%b f=%b",
                             n, i, sel_a[i], sel_b[i], stall_o[i], flush_o[i],
                             m_sel(i, id_rs1), m_sel(i, id_rs2), m_stall(i), m_flush(i));
                end
`ifdef HAZARD_PERF_EN
                checks++;
                if (scnt_o[i] !== 32'(sc_m[i]) || fcnt_o[i] !== 32'(fc_m[i])) begin
                    errors++;
                    $display("FAIL random_cnt n%0d dut%0d got s=%0d f=%0d want s=%0d f=%0d",
                             n, i, scnt_o[i], fcnt_o[i], sc_m[i], fc_m[i]);
                end
`endif
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit exceeded");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        brj = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        m_reset();
        test_reset();
        test_alu_fwd();
        test_two_back();
        test_load_use();
        test_x0();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 2, number of in-flight writeback stages tracked for forwarding (1..4).
REQ-002 SHALL have parameter FLUSH_CYC, default 1, number of cycles flush stays high per taken branch/jump (1..4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_valid  input  1  decode-stage instruction valid.
REQ-006 SHALL have port id_rs1 / id_rs2  input  5 each  decode source register indices.
REQ-007 SHALL have port id_rd  input  5  decode destination register index.
REQ-008 SHALL have port id_rf_en  input  1  decode instruction writes the register file.
REQ-009 SHALL have port id_is_load  input  1  decode instruction is a load.
REQ-010 SHALL have port brj  input  1  branch taken or jump resolved this cycle.
REQ-011 SHALL have port sel_a_fwd / sel_b_fwd  output  3 each  0 = register file, k = forward from tracked stage k (1 = youngest).
REQ-012 SHALL have port stall  output  1  hold PC and decode register, insert bubble.
REQ-013 SHALL have port flush  output  1  kill the instruction in decode.

Function
REQ-014 SHALL keep an NSTAGE-deep shift register of {valid, rd, rf_en, is_load}; entry 1 is the youngest.
REQ-015 Each cycle, entry k+1 SHALL take entry k; entry 1 SHALL take the decode fields with valid = id_valid & ~stall & ~flush.
REQ-016 sel_a_fwd SHALL be the smallest k with entry k valid, rf_en=1, rd=id_rs1 and rd!=0; otherwise 0. sel_b_fwd SHALL follow the same rule on id_rs2.
REQ-017 A source index of 0 SHALL never forward; the select SHALL be 0.
REQ-018 stall SHALL be combinational: high when id_valid=1, entry 1 is a valid load with rf_en=1, rd!=0, rd equal to id_rs1 or id_rs2, and flush=0.
REQ-019 During stall, entry 1 SHALL load a bubble (valid=0). Forwarding from entry 2 SHALL resolve the dependency on the next cycle.
REQ-020 A flush counter SHALL load FLUSH_CYC-1 when brj=1. flush SHALL equal brj OR (counter != 0). The counter SHALL decrement while it is nonzero.
REQ-021 brj during an active flush SHALL reload the counter to FLUSH_CYC-1, extending the flush.
REQ-022 When brj and a load-use condition occur together, flush SHALL win: stall=0 and entry 1 gets a bubble.
REQ-023 Entries already in the shift register SHALL NOT be invalidated by flush, because they are older than the branch.
REQ-024 Outputs SHALL have zero-cycle latency from decode inputs; only the shift register and counter add state.

Reset
REQ-025 rst=1 SHALL clear all shift-register valid bits and the flush counter at once, independent of clk.
REQ-026 During and right after reset: sel_a_fwd=0, sel_b_fwd=0, stall=0; flush=brj.
REQ-027 Reset asserted mid-flush or mid-stall SHALL abandon the operation. No residual flush or stall after release.

Configuration
REQ-028 Macro HAZARD_PERF_EN, when defined, SHALL add outputs stall_cnt and flush_cnt (32-bit each).
REQ-029 With HAZARD_PERF_EN, each counter SHALL increment on every cycle its signal is high, wrap at 2^32, and clear on rst.
REQ-030 Without HAZARD_PERF_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-031 Test ALU forwarding: issue write x5, then next-cycle read rs1=x5 -> sel_a_fwd=1, sel_b_fwd=0, stall=0.
REQ-032 Test two-back forwarding and youngest priority: NSTAGE=2, write x7, write x7, then read rs2=x7 -> sel_b_fwd=1. With an unrelated middle instruction -> sel_b_fwd=2.
REQ-033 Test load-use: load x3, then read rs1=x3 -> stall=1 for exactly 1 cycle, then sel_a_fwd=2 with stall=0.
REQ-034 Test x0 write/read: write x0 then read rs1=x0 -> sel_a_fwd=0.
REQ-035 Test flush: FLUSH_CYC=2, brj pulse -> flush high 2 cycles. brj coinciding with load-use -> stall=0, flush=1.
REQ-036 Test reset mid-flush: FLUSH_CYC=3, assert rst 1 cycle after brj -> flush=0 and all selects 0 after release. With HAZARD_PERF_EN, counters read 0.
